// File: rtl/exe_arb_pkg.sv
// Shared types, widths and the round-robin pointer helper for exe_unit_arbiter.
package exe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int STATUS_W = 2;
  localparam int CNT_W    = $clog2(8);
  localparam int PTR_W    = 2;  // wide enough for NREQ up to 4

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input int nreq);
    logic [PTR_W-1:0] nxt;
    if (int'(ptr) >= nreq - 1) nxt = '0;
    else                       nxt = ptr + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/exe_arb_rr_pick.sv
// Combinational circular-priority picker: first valid requester at or after ptr_i wins.
module exe_arb_rr_pick
  import exe_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] grant_o,
  output logic             any_o
);

  logic [2*NREQ-1:0] rot;

  // Rotating a doubled copy puts requester ptr_i at bit 0; scanning downward leaves the lowest offset as winner.
  always_comb begin
    rot     = {valid_i, valid_i} >> ptr_i;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_o = PTR_W'((int'(ptr_i) + k) % NREQ);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Round-robin share of one exe unit among NREQ requesters; one op in flight, response LAT+1 edges after accept.
// Build option EXE_ARB_LOCK_EN adds i_req_lock, which keeps priority on the owner for back-to-back atomic ops.
module exe_unit_arbiter
  import exe_arb_pkg::*;
#(
  parameter int M    = 4,
  parameter int N    = 2,
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic                i_clk,
  input  logic                i_rsn,
  input  logic [NREQ-1:0]     i_req_valid,
`ifdef EXE_ARB_LOCK_EN
  input  logic [NREQ-1:0]     i_req_lock,
`endif
  output logic [NREQ-1:0]     o_req_ready,
  input  logic [NREQ*N-1:0]   i_req_oper,
  input  logic [NREQ*M-1:0]   i_req_argA,
  input  logic [NREQ*M-1:0]   i_req_argB,
  output logic [NREQ-1:0]     o_rsp_valid,
  input  logic [NREQ-1:0]     i_rsp_ready,
  output logic [M-1:0]        o_rsp_result,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic [N-1:0]        o_exe_oper,
  output logic [M-1:0]        o_exe_argA,
  output logic [M-1:0]        o_exe_argB,
  input  logic [M-1:0]        i_exe_result,
  input  logic [STATUS_W-1:0] i_exe_status
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N-1:0]        oper_q, oper_d;
  logic [M-1:0]        arga_q, arga_d, argb_q, argb_d;
  logic [M-1:0]        result_q, result_d;
  logic [STATUS_W-1:0] status_q, status_d;

  logic [PTR_W-1:0]    pick_grant;
  logic                pick_any;
  logic [NREQ-1:0]     pick_oh, grant_oh;
  logic                hold_ptr;

  exe_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (i_req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  assign pick_oh  = ONE << pick_grant;
  assign grant_oh = ONE << grant_q;

`ifdef EXE_ARB_LOCK_EN
  assign hold_ptr = |(i_req_lock & grant_oh);
`else
  assign hold_ptr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    oper_d      = oper_q;
    arga_d      = arga_q;
    argb_d      = argb_q;
    result_d    = result_q;
    status_d    = status_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          o_req_ready = pick_oh;
          grant_d     = pick_grant;
          cnt_d       = CNT_W'(LAT);
          state_d     = EXEC;
          for (int k = 0; k < NREQ; k++) begin
            if (pick_grant == PTR_W'(k)) begin
              oper_d = i_req_oper[k*N +: N];
              arga_d = i_req_argA[k*M +: M];
              argb_d = i_req_argB[k*M +: M];
            end
          end
        end
      end
      EXEC: begin
        // Operands went out on the accept edge, so the exe output is settled once cnt runs out.
        if (cnt_q == '0) begin
          result_d = i_exe_result;
          status_d = i_exe_status;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        o_rsp_valid = grant_oh;
        if (|(i_rsp_ready & grant_oh)) begin
          ptr_d   = hold_ptr ? grant_q : rr_next(grant_q, NREQ);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      oper_q   <= '0;
      arga_q   <= '0;
      argb_q   <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      oper_q   <= oper_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_exe_oper   = oper_q;
  assign o_exe_argA   = arga_q;
  assign o_exe_argB   = argb_q;
  assign o_rsp_result = result_q;
  assign o_rsp_status = status_q;

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Bench for exe_unit_arbiter: registered exe stub (result=A^B, status=oper), transaction-level model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_exe_unit_arbiter;

  localparam int M    = 4;
  localparam int N    = 2;
  localparam int NREQ = 2;
  localparam int LAT  = 1;
  localparam int IW   = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_oper = '0;
  logic [NREQ*M-1:0] req_a = '0;
  logic [NREQ*M-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [M-1:0]      rsp_result;
  logic [1:0]        rsp_status;
  logic [N-1:0]      exe_oper;
  logic [M-1:0]      exe_a, exe_b, exe_result;
  logic [1:0]        exe_status;
`ifdef EXE_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock = '0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  exe_unit_arbiter #(.M(M), .N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .i_clk        (clk),
    .i_rsn        (rst_n),
    .i_req_valid  (req_valid),
`ifdef EXE_ARB_LOCK_EN
    .i_req_lock   (req_lock),
`endif
    .o_req_ready  (req_ready),
    .i_req_oper   (req_oper),
    .i_req_argA   (req_a),
    .i_req_argB   (req_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_status (rsp_status),
    .o_exe_oper   (exe_oper),
    .o_exe_argA   (exe_a),
    .o_exe_argB   (exe_b),
    .i_exe_result (exe_result),
    .i_exe_status (exe_status)
  );

  // Exe unit stub: LAT register stages from operands to result/status.
  logic [M+N-1:0] pipe [LAT];
  initial foreach (pipe[s]) pipe[s] = '0;
  always @(posedge clk) begin
    pipe[0] <= {exe_a ^ exe_b, exe_oper};
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign exe_result = pipe[LAT-1][M+N-1:N];
  assign exe_status = pipe[LAT-1][N-1:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_valid(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++)
      if (v[IW'((p + off) % NREQ)]) return (p + off) % NREQ;
    return -1;
  endfunction

  // Transaction-level model: one op at a time, response visible LAT+1 edges after accept.
  bit           m_active = 1'b0;
  int           m_ptr = 0, m_owner = 0, m_age = 0, m_g = 0;
  logic [N-1:0] m_oper = '0;
  logic [M-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [1:0]   m_stat = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_ptr = 0; m_owner = 0; m_age = 0;
      m_oper = '0; m_a = '0; m_b = '0; m_res = '0; m_stat = '0;
    end else if (!m_active) begin
      m_g = first_valid(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_active = 1'b1;
        m_owner  = m_g;
        m_age    = 0;
        m_oper   = req_oper[m_g*N +: N];
        m_a      = req_a[m_g*M +: M];
        m_b      = req_b[m_g*M +: M];
      end
    end else if (m_age >= LAT + 1) begin
      if (rsp_ready[IW'(m_owner)]) begin
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
`ifdef EXE_ARB_LOCK_EN
        if (req_lock[IW'(m_owner)]) m_ptr = m_owner;
`endif
      end
    end else begin
      m_age++;
      if (m_age == LAT + 1) begin
        m_res  = m_a ^ m_b;
        m_stat = m_oper;
      end
    end
  end

  logic [NREQ-1:0] exp_ready, exp_rv;
  int              c_g;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_ready = '0;
      exp_rv    = '0;
      if (!m_active) begin
        c_g = first_valid(req_valid, m_ptr);
        if (c_g >= 0) exp_ready = ONE << c_g;
      end else if (m_age >= LAT + 1) begin
        exp_rv = ONE << m_owner;
      end
      chk("m_req_ready", req_ready, exp_ready);
      chk("m_ready_onehot", ($countones(req_ready) <= 1), 1);
      chk("m_rsp_valid", rsp_valid, exp_rv);
      chk("m_rsp_result", rsp_result, m_res);
      chk("m_rsp_status", rsp_status, m_stat);
      chk("m_exe_oper", exe_oper, m_oper);
      chk("m_exe_argA", exe_a, m_a);
      chk("m_exe_argB", exe_b, m_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [N-1:0] op,
                         input logic [M-1:0] a, input logic [M-1:0] b);
    req_valid[IW'(i)]  = v;
    req_oper[i*N +: N] = op;
    req_a[i*M +: M]    = a;
    req_b[i*M +: M]    = b;
  endtask

  // Waits (bounded) at negedges until the given output pattern appears; leaves time at that negedge.
  task automatic wait_neg(input string name, input bit use_rsp, input logic [NREQ-1:0] pat);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if ((use_rsp ? rsp_valid : req_ready) == pat) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  task automatic collect(input int cnt, output int n, output int g [4], output int t [4]);
    n = 0;
    for (int c = 0; c < 80 && n < cnt; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g[n] = req_ready[1] ? 1 : 0;
        t[n] = cyc;
        n++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int ng;
  int gs [4];
  int ts [4];

  initial begin
    rsp_ready = '0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_exe_oper", exe_oper, 0);
    chk("rst_exe_argA", exe_a, 0);
    chk("rst_exe_argB", exe_b, 0);
    rst_n = 1'b1;

    // Single request from req0; response 2 edges after accept.
    set_req(0, 1'b1, 2'b01, 4'b1011, 4'b0001);
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_ready_drop", req_ready, 0);
    chk("t1_exe_argA", exe_a, 4'b1011);
    chk("t1_rsp_early0", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_early1", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_result", rsp_result, 4'b1010);
    chk("t1_status", rsp_status, 2'b01);
    tick();
    rsp_ready = 2'b11;
    tick();
    @(negedge clk);
    chk("t1_rsp_done", rsp_valid, 0);

    // Both valid from reset: alternating grants at one per LAT+3 cycles.
    do_reset();
    set_req(0, 1'b1, 2'b10, 4'b0110, 4'b0011);
    set_req(1, 1'b1, 2'b11, 4'b1111, 4'b0101);
    collect(4, ng, gs, ts);
    tick();
    req_valid = '0;
    chk("t2_count", ng, 4);
    chk("t2_g0", gs[0], 0);
    chk("t2_g1", gs[1], 1);
    chk("t2_g2", gs[2], 0);
    chk("t2_g3", gs[3], 1);
    chk("t2_spacing", ts[1] - ts[0], 4);
    repeat (8) tick();

    // req1 response stalled 3 cycles while req0 waits.
    rsp_ready = 2'b01;
    set_req(1, 1'b1, 2'b01, 4'b1100, 4'b1010);
    wait_neg("t3_req1_ready", 1'b0, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 2'b11, 4'b0011, 4'b0101);
    wait_neg("t3_rsp1", 1'b1, 2'b10);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 2'b10);
      chk("t3_hold_result", rsp_result, 4'b0110);
      chk("t3_no_accept", req_ready, 0);
      tick();
    end
    rsp_ready = 2'b11;
    tick();
    @(negedge clk);
    chk("t3_req0_after", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    wait_neg("t3_rsp0", 1'b1, 2'b01);
    chk("t3_result0", rsp_result, 4'b0110);
    chk("t3_status0", rsp_status, 2'b11);
    repeat (4) tick();

    // Reset during EXEC discards the op; pointer restarts at 0.
    set_req(0, 1'b1, 2'b10, 4'b0111, 4'b0001);
    wait_neg("t4_ready", 1'b0, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_exe_argA", exe_a, 4'b0111);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ready", req_ready, 0);
    chk("t4_rst_rsp_valid", rsp_valid, 0);
    chk("t4_rst_result", rsp_result, 0);
    chk("t4_rst_status", rsp_status, 0);
    chk("t4_rst_exe_oper", exe_oper, 0);
    chk("t4_rst_exe_argA", exe_a, 0);
    chk("t4_rst_exe_argB", exe_b, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t4_no_rsp", rsp_valid, 0);
    end
    tick();
    set_req(0, 1'b1, 2'b00, 4'b0001, 4'b0001);
    set_req(1, 1'b1, 2'b10, 4'b1000, 4'b0001);
    @(negedge clk);
    chk("t4_ptr_restart", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    wait_neg("t4_req1_next", 1'b0, 2'b10);
    tick();
    req_valid = '0;
    repeat (6) tick();

`ifdef EXE_ARB_LOCK_EN
    // Lock on req0: three consecutive grants, then req1 once the lock drops.
    do_reset();
    req_lock = 2'b01;
    set_req(0, 1'b1, 2'b01, 4'b0010, 4'b0001);
    set_req(1, 1'b1, 2'b01, 4'b0100, 4'b0001);
    collect(3, ng, gs, ts);
    tick();
    req_lock = 2'b00;
    chk("lk_count", ng, 3);
    chk("lk_g0", gs[0], 0);
    chk("lk_g1", gs[1], 0);
    chk("lk_g2", gs[2], 0);
    collect(1, ng, gs, ts);
    tick();
    req_valid = '0;
    chk("lk_g3", gs[0], 1);
    repeat (8) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
